// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared widths, byte counts and format encoding for the result path
package tpu_pkg;

  localparam int ACC_W      = 16;
  localparam int OUT_W      = 8;
  localparam int NUM_RES    = 4;
  localparam int BYTES_SAT  = 4;
  localparam int BYTES_FULL = 8;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_FULL = 1'b1
  } mode_e;

  // Element 0 is c00, element 3 is c11.
  typedef logic [NUM_RES-1:0][ACC_W-1:0] res_set_t;

endpackage

// File: rtl/sat_s16_to_s8.sv
// rtl/sat_s16_to_s8.sv - combinational signed saturation of one accumulator result to a host byte
module sat_s16_to_s8
  import tpu_pkg::*;
(
  input  logic [ACC_W-1:0] value_i,
  output logic [OUT_W-1:0] sat_o
);

  // The value fits in OUT_W signed bits only when every bit from the top down
  // to the byte's sign bit is a copy of the sign.
  logic [ACC_W-OUT_W:0] head;

  assign head = value_i[ACC_W-1:OUT_W-1];

  always_comb begin
    sat_o = value_i[OUT_W-1:0];
    if ((head != '0) && (head != '1)) begin
      sat_o = value_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - double-buffered snapshot of the 2x2 results, streamed to the host a byte per pop
module result_drain
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             mode,
  input  logic [ACC_W-1:0] c00,
  input  logic [ACC_W-1:0] c01,
  input  logic [ACC_W-1:0] c10,
  input  logic [ACC_W-1:0] c11,
  input  logic             rd_en,
  input  logic             clr_ovr,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             pend_full,
  output logic [3:0]       bytes_left,
  output logic             overrun
);

  res_set_t         act_res_q, act_res_d;
  res_set_t         pend_res_q, pend_res_d;
  res_set_t         cap_res;
  mode_e            act_mode_q, act_mode_d;
  mode_e            pend_mode_q, pend_mode_d;
  logic             act_full_q, act_full_d;
  logic             pend_full_q, pend_full_d;
  logic [2:0]       idx_q, idx_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             overrun_q, overrun_d;

  logic             pop;
  logic             last;
  logic             drop;
  logic [2:0]       last_idx;
  logic [1:0]       res_sel;
  logic [ACC_W-1:0] sel_res;
  logic [OUT_W-1:0] sat_byte;
  logic [OUT_W-1:0] full_byte;

  assign cap_res  = {c11, c10, c01, c00};
  assign pop      = rd_en & act_full_q;
  assign last_idx = (act_mode_q == MODE_FULL) ? 3'(BYTES_FULL - 1) : 3'(BYTES_SAT - 1);
  assign last     = pop & (idx_q == last_idx);

  // Pops are resolved first; the capture then lands in whichever bank is free
  // afterwards, which gives the no-bubble handover and the no-loss swap.
  always_comb begin
    act_res_d   = act_res_q;
    act_mode_d  = act_mode_q;
    act_full_d  = act_full_q;
    pend_res_d  = pend_res_q;
    pend_mode_d = pend_mode_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    drop        = 1'b0;

    if (pop) begin
      idx_d = idx_q + 3'd1;
    end

    if (last) begin
      idx_d = '0;
      if (pend_full_q) begin
        act_res_d   = pend_res_q;
        act_mode_d  = pend_mode_q;
        pend_full_d = 1'b0;
      end else begin
        act_full_d  = 1'b0;
      end
    end

    if (capture) begin
      if (!act_full_d) begin
        act_res_d   = cap_res;
        act_mode_d  = mode_e'(mode);
        act_full_d  = 1'b1;
        idx_d       = '0;
      end else if (!pend_full_d) begin
        pend_res_d  = cap_res;
        pend_mode_d = mode_e'(mode);
        pend_full_d = 1'b1;
      end else begin
        drop        = 1'b1;
      end
    end

    overrun_d = drop | (overrun_q & ~clr_ovr);
  end

  // The registered byte is looked up from the next-state bank so it appears
  // in the same cycle as the capture or pop that selects it.
  assign res_sel   = (act_mode_d == MODE_FULL) ? idx_d[2:1] : idx_d[1:0];
  assign sel_res   = act_res_d[res_sel];
  assign full_byte = idx_d[0] ? sel_res[ACC_W-1:OUT_W] : sel_res[OUT_W-1:0];

  sat_s16_to_s8 u_sat (
    .value_i (sel_res),
    .sat_o   (sat_byte)
  );

  always_comb begin
    out_data_d = '0;
    if (act_full_d) begin
      out_data_d = (act_mode_d == MODE_FULL) ? full_byte : sat_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_res_q   <= '0;
      act_mode_q  <= MODE_SAT;
      act_full_q  <= 1'b0;
      pend_res_q  <= '0;
      pend_mode_q <= MODE_SAT;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      act_res_q   <= act_res_d;
      act_mode_q  <= act_mode_d;
      act_full_q  <= act_full_d;
      pend_res_q  <= pend_res_d;
      pend_mode_q <= pend_mode_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = act_full_q;
  assign pend_full  = pend_full_q;
  assign overrun    = overrun_q;
  assign bytes_left = act_full_q
                    ? (((act_mode_q == MODE_FULL) ? 4'(BYTES_FULL) : 4'(BYTES_SAT)) - {1'b0, idx_q})
                    : 4'd0;

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - scoreboard bench for result_drain with directed capture/pop vectors
module tb_result_drain;

  logic        clk;
  logic        rst;
  logic        capture;
  logic        mode;
  logic [15:0] c00, c01, c10, c11;
  logic        rd_en;
  logic        clr_ovr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        pend_full;
  logic [3:0]  bytes_left;
  logic        overrun;

  result_drain dut (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .mode       (mode),
    .c00        (c00),
    .c01        (c01),
    .c10        (c10),
    .c11        (c11),
    .rd_en      (rd_en),
    .clr_ovr    (clr_ovr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .pend_full  (pend_full),
    .bytes_left (bytes_left),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] left;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bytes are listed first-to-last in the high-to-low lanes of a 64-bit word.
  task automatic push_set(input logic [63:0] bytes, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = bytes[8*(n-1-k) +: 8];
      e.left = 4'(n - k);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic m, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input logic [15:0] d);
    capture = 1'b1;
    mode    = m;
    c00 = a; c01 = b; c10 = c; c11 = d;
    step();
    capture = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) step();
    rd_en = 1'b0;
  endtask

  // Monitor: every consumed byte is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rd_en && out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_data", 32'(out_data), 32'(e.data));
        check("pop_bytes_left", 32'(bytes_left), 32'(e.left));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; capture = 1'b0; mode = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;
    step(); step();
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_pend_full", 32'(pend_full), 0);
    check("rst_bytes_left", 32'(bytes_left), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step();

    // Mode 0 saturation
    push_set(64'h05_7F_80_FB, 4);
    cap(1'b0, 16'h0005, 16'h00C8, 16'hFF38, 16'hFFFB);
    check("m0_first_valid", 32'(out_valid), 1);
    check("m0_first_data", 32'(out_data), 32'h05);
    pop_n(4);
    check("m0_valid_falls", 32'(out_valid), 0);
    check("m0_left_zero", 32'(bytes_left), 0);
    check("m0_data_zero", 32'(out_data), 0);

    // Mode 1 ordering
    push_set(64'h34_12_CD_AB_01_00_00_80, 8);
    cap(1'b1, 16'h1234, 16'hABCD, 16'h0001, 16'h8000);
    check("m1_left8", 32'(bytes_left), 8);
    pop_n(8);
    check("m1_valid_falls", 32'(out_valid), 0);

    // Double buffer with no bubble
    push_set(64'h11_22_7F_80, 4);
    cap(1'b0, 16'h0011, 16'h0022, 16'h7FFF, 16'h8000);
    rd_en = 1'b1;
    step();
    push_set(64'h02_01_04_03_06_05_08_07, 8);
    cap(1'b1, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    check("db_pend_full_set", 32'(pend_full), 1);
    step();
    check("db_pend_full_hold", 32'(pend_full), 1);
    step();
    check("db_pend_full_drop", 32'(pend_full), 0);
    check("db_b_left8", 32'(bytes_left), 8);
    for (int i = 0; i < 8; i++) begin
      check("db_no_bubble", 32'(out_valid), 1);
      step();
    end
    rd_en = 1'b0;
    check("db_done", 32'(out_valid), 0);

    // Overflow, coincident capture, clear and set-dominates-clear
    push_set(64'h01_02_03_04, 4);
    cap(1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push_set(64'h05_06_07_08, 4);
    cap(1'b0, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    check("ov_pend_full", 32'(pend_full), 1);
    check("ov_not_yet", 32'(overrun), 0);
    cap(1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
    check("ov_set", 32'(overrun), 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ov_cleared", 32'(overrun), 0);
    rd_en = 1'b1;
    repeat (3) step();
    push_set(64'h09_0A_0B_0C, 4);
    cap(1'b0, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
    rd_en = 1'b0;
    check("ov_swap_no_loss", 32'(overrun), 0);
    check("ov_swap_pend", 32'(pend_full), 1);
    check("ov_swap_left", 32'(bytes_left), 4);
    check("ov_swap_data", 32'(out_data), 32'h05);
    clr_ovr = 1'b1;
    cap(1'b0, 16'h6666, 16'h6666, 16'h6666, 16'h6666);
    clr_ovr = 1'b0;
    check("ov_set_dominates", 32'(overrun), 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ov_clear_again", 32'(overrun), 0);
    pop_n(8);
    check("ov_drained", 32'(out_valid), 0);

    // Stall mid-set, inputs wiggling off-capture, idle pops
    push_set(64'hB2_A1_D4_C3_F6_E5_89_07, 8);
    cap(1'b1, 16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789);
    pop_n(3);
    for (int i = 0; i < 5; i++) begin
      c00 = 16'(i * 16'h1111); c01 = ~c00; mode = ~mode;
      step();
      check("stall_data", 32'(out_data), 32'hC3);
      check("stall_left", 32'(bytes_left), 5);
    end
    pop_n(5);
    rd_en = 1'b1;
    repeat (3) step();
    rd_en = 1'b0;
    check("idle_valid", 32'(out_valid), 0);
    check("idle_data", 32'(out_data), 0);
    check("idle_left", 32'(bytes_left), 0);
    check("idle_pend", 32'(pend_full), 0);

    // Capture on the last pop with PEND empty starts next cycle
    push_set(64'h40_80_7F_80, 4);
    cap(1'b0, 16'h0040, 16'hFF80, 16'h0080, 16'hFF7F);
    rd_en = 1'b1;
    repeat (3) step();
    push_set(64'h01_02_03_04, 4);
    cap(1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    rd_en = 1'b0;
    check("handover_valid", 32'(out_valid), 1);
    check("handover_left", 32'(bytes_left), 4);
    check("handover_pend", 32'(pend_full), 0);
    check("handover_data", 32'(out_data), 32'h01);
    pop_n(4);

    // Reset mid-drain with PEND occupied
    push_set(64'h11_11_22_22_33_33_44_44, 8);
    cap(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    cap(1'b0, 16'h0077, 16'h0077, 16'h0077, 16'h0077);
    pop_n(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_pend", 32'(pend_full), 0);
    check("mid_rst_left", 32'(bytes_left), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    push_set(64'h10_20_30_40, 4);
    cap(1'b0, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    check("post_rst_first", 32'(out_data), 32'h10);
    pop_n(4);
    check("post_rst_done", 32'(out_valid), 0);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
